imem_stream: RTL and testbench

Parametrised successor to the instruction memory: word-organised storage with NREAD byte-addressed read ports, a direct single-word write port, and a streaming loader FSM. The loader fills consecutive words from a valid/ready stream, typically a host or DMA path. After reset the block zeroes itself one word per cycle. It sits between the program loader and the core front-end, which fetches one or more instructions per cycle.

---
 rtl/imem_stream.sv | 142 ++++++++++++++
 tb/tb_imem_stream.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream.sv
// Word-organised instruction memory with NREAD byte-addressed read ports,
// a direct write port and a valid/ready streaming loader with self-clear.
module imem_stream #(
    parameter int DEPTH        = 256,
    parameter int WIDTH        = 32,
    parameter int NREAD        = 2,
    parameter int READ_LATENCY = 0,
    localparam int OFS = $clog2(WIDTH / 8),
    localparam int IW  = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREAD*WIDTH-1:0] rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_fault,
    input  logic                   wr_valid,
    input  logic [WIDTH-1:0]       wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_err,
    input  logic                   ld_start,
    input  logic [WIDTH-1:0]       ld_base,
    input  logic [IW:0]            ld_count,
    input  logic                   ld_valid,
    input  logic [WIDTH-1:0]       ld_data,
    output logic                   ld_ready,
    output logic                   ld_busy,
    output logic                   ld_done,
    output logic                   ld_err
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t        state;
    logic [IW-1:0] clr_ptr;
    logic [IW-1:0] ptr;
    logic [IW:0]   rem;

    // Aligned and no bits set above the word index
    function automatic logic addr_ok(input logic [WIDTH-1:0] a);
        return (a[OFS-1:0] == '0) && ((a >> (OFS + IW)) == '0);
    endfunction

    logic beat;
    logic wr_ok;

    assign beat     = (state == LOAD) && ld_valid;
    assign wr_ok    = wr_valid && (state == IDLE) && addr_ok(wr_addr);
    assign ld_ready = (state == LOAD);
    assign ld_busy  = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ptr     <= '0;
            rem     <= '0;
            wr_err  <= 1'b0;
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
        end else begin
            wr_err  <= wr_valid && !wr_ok;
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
            unique case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    ld_err  <= ld_start;
                    if (clr_ptr == IW'(DEPTH - 1))
                        state <= IDLE;
                end
                IDLE: begin
                    if (ld_start) begin
                        if (!addr_ok(ld_base)) begin
                            ld_err <= 1'b1;
                        end else if (ld_count == '0) begin
                            ld_done <= 1'b1;
                        end else begin
                            ptr   <= ld_base[OFS +: IW];
                            rem   <= ld_count;
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        ptr <= ptr + 1'b1;
                        rem <= rem - 1'b1;
                        if (rem == (IW+1)'(1)) begin
                            ld_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Loader beats win over direct writes, which are rejected outside IDLE
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR)
                mem[clr_ptr] <= '0;
            else if (beat)
                mem[ptr] <= ld_data;
            else if (wr_ok)
                mem[wr_addr[OFS +: IW]] <= wr_data;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [WIDTH-1:0] a;
        logic             ok;
        logic [WIDTH-1:0] word;

        assign a    = rd_addr[p*WIDTH +: WIDTH];
        assign ok   = addr_ok(a);
        assign word = (ok && state != CLEAR) ? mem[a[OFS +: IW]] : '0;

        if (READ_LATENCY == 0) begin : g_comb
            assign rd_data[p*WIDTH +: WIDTH] = word;
            assign rd_fault[p]               = !ok;
        end else begin : g_reg
            always_ff @(posedge clock) begin
                if (reset) begin
                    rd_data[p*WIDTH +: WIDTH] <= '0;
                    rd_fault[p]               <= 1'b0;
                end else begin
                    rd_data[p*WIDTH +: WIDTH] <= word;
                    rd_fault[p]               <= !ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_stream.sv
// Directed bench for imem_stream: combinational-read instance plus a
// registered-read instance, table-driven reads and hand-written sequences.
module tb_imem_stream;

    localparam int DEPTH = 16;
    localparam int W     = 32;
    localparam int NR    = 2;
    localparam int IW    = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NR*W-1:0] rd_addr = '0;
    logic [NR*W-1:0] rd_data;
    logic [NR-1:0]   rd_fault;
    logic            wr_valid = 1'b0;
    logic [W-1:0]    wr_addr = '0;
    logic [W-1:0]    wr_data = '0;
    logic            wr_err;
    logic            ld_start = 1'b0;
    logic [W-1:0]    ld_base = '0;
    logic [IW:0]     ld_count = '0;
    logic            ld_valid = 1'b0;
    logic [W-1:0]    ld_data = '0;
    logic            ld_ready, ld_busy, ld_done, ld_err;

    logic [NR*W-1:0] b_rd_addr = '0;
    logic [NR*W-1:0] b_rd_data;
    logic [NR-1:0]   b_rd_fault;
    logic            b_wr_valid = 1'b0;
    logic [W-1:0]    b_wr_addr = '0;
    logic [W-1:0]    b_wr_data = '0;
    logic            b_wr_err;
    logic            b_ld_ready, b_ld_busy, b_ld_done, b_ld_err;

    imem_stream #(.DEPTH(DEPTH), .WIDTH(W), .NREAD(NR), .READ_LATENCY(0)) dut (
        .clock(clock), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_fault(rd_fault),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err)
    );

    imem_stream #(.DEPTH(DEPTH), .WIDTH(W), .NREAD(NR), .READ_LATENCY(1)) dut_r (
        .clock(clock), .reset(reset),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_fault(b_rd_fault),
        .wr_valid(b_wr_valid), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_err(b_wr_err),
        .ld_start(1'b0), .ld_base('0), .ld_count('0),
        .ld_valid(1'b0), .ld_data('0), .ld_ready(b_ld_ready),
        .ld_busy(b_ld_busy), .ld_done(b_ld_done), .ld_err(b_ld_err)
    );

    typedef struct {
        logic [W-1:0] a0, a1, d0, d1;
        logic         f0, f1;
    } vec_t;

    vec_t tbl [7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int dn;

        tbl[0] = '{32'h38, 32'h3C, 32'd1, 32'd2, 1'b0, 1'b0};
        tbl[1] = '{32'h00, 32'h04, 32'd3, 32'd4, 1'b0, 1'b0};
        tbl[2] = '{32'h08, 32'h0A, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1};
        tbl[3] = '{32'h14, 32'h0C, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[4] = '{32'h40, 32'h41, 32'h0, 32'h0, 1'b1, 1'b1};
        tbl[5] = '{32'h3C, 32'h08, 32'd2, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[6] = '{32'h34, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b1};

        // reset state
        step();
        step();
        chk("rst_busy", ld_busy, 1);
        chk("rst_ready", ld_ready, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_lderr", ld_err, 0);
        chk("rst_wrerr", wr_err, 0);
        chk("rst_rd", rd_data[31:0], 0);
        chk("rst_rd_r", b_rd_data[31:0], 0);
        chk("rst_fault_r", b_rd_fault, 0);

        reset = 1'b0;
        n = 0;
        while (ld_busy && n < 40) begin
            step();
            n++;
        end
        chk("clear_cycles", n, DEPTH);

        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = {32'(i * 4), 32'(i * 4)};
            #1;
            chk("cleared_p0", rd_data[31:0], 0);
            chk("cleared_p1", rd_data[63:32], 0);
        end

        // direct writes: aligned then misaligned
        wr_valid = 1'b1;
        wr_addr  = 32'h08;
        wr_data  = 32'hDEADBEEF;
        step();
        chk("wr_ok_noerr", wr_err, 0);
        wr_addr = 32'h0A;
        wr_data = 32'h12345678;
        step();
        wr_valid = 1'b0;
        chk("wr_mis_err", wr_err, 1);
        step();
        chk("wr_err_pulse", wr_err, 0);

        // wrapping load with gapped stream and intruding requests
        ld_base  = 32'h38;
        ld_count = 5'd4;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("load_busy", ld_busy, 1);
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            ld_valid = (k % 2 == 0);
            ld_data  = 32'(k / 2 + 1);
            if (k == 1) begin
                wr_valid = 1'b1;
                wr_addr  = 32'h14;
                wr_data  = 32'h00000BAD;
                ld_start = 1'b1;
                ld_base  = 32'h0;
                ld_count = 5'd2;
            end
            if (k < 7) chk("load_ready", ld_ready, 1);
            step();
            wr_valid = 1'b0;
            ld_start = 1'b0;
            ld_valid = 1'b0;
            dn += int'(ld_done);
            if (k == 1) chk("load_wr_err", wr_err, 1);
            if (k == 5) chk("load_not_done", ld_done, 0);
            if (k == 6) begin
                chk("load_done", ld_done, 1);
                chk("load_idle", ld_busy, 0);
            end
        end
        chk("load_done_once", dn, 1);

        foreach (tbl[i]) begin
            rd_addr = {tbl[i].a1, tbl[i].a0};
            #1;
            chk("tbl_d0", rd_data[31:0], tbl[i].d0);
            chk("tbl_d1", rd_data[63:32], tbl[i].d1);
            chk("tbl_f0", rd_fault[0], tbl[i].f0);
            chk("tbl_f1", rd_fault[1], tbl[i].f1);
        end

        // misaligned base then zero count
        ld_base  = 32'h41;
        ld_count = 5'd3;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("ld_err", ld_err, 1);
        chk("ld_err_busy", ld_busy, 0);
        chk("ld_err_nodone", ld_done, 0);
        step();
        chk("ld_err_pulse", ld_err, 0);
        ld_base  = 32'h38;
        ld_count = 5'd0;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("zero_done", ld_done, 1);
        chk("zero_busy", ld_busy, 0);
        step();
        chk("zero_pulse", ld_done, 0);
        rd_addr = {32'h0, 32'h38};
        #1;
        chk("zero_nowrite", rd_data[31:0], 1);

        // registered reads: read-before-write and registered fault
        b_rd_addr  = {32'h06, 32'h04};
        b_wr_valid = 1'b1;
        b_wr_addr  = 32'h04;
        b_wr_data  = 32'hA5;
        step();
        b_wr_valid = 1'b0;
        chk("rbw_old", b_rd_data[31:0], 0);
        chk("rbw_fault", b_rd_fault, 2'b10);
        step();
        chk("rbw_new", b_rd_data[31:0], 32'hA5);

        // reset in the middle of a load
        ld_base  = 32'h0;
        ld_count = 5'd4;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 32'h77;
        step();
        ld_valid = 1'b0;
        rd_addr  = '0;
        #1;
        chk("midload_beat", rd_data[31:0], 32'h77);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", ld_busy, 1);
        chk("abort_ready", ld_ready, 0);
        chk("abort_nodone", ld_done, 0);
        chk("abort_rd_r", b_rd_data[31:0], 0);
        n  = 0;
        dn = 0;
        while (ld_busy && n < 40) begin
            step();
            n++;
            dn += int'(ld_done);
        end
        chk("abort_clear_cycles", n, DEPTH);
        chk("abort_no_done", dn, 0);
        #1;
        chk("abort_cleared", rd_data[31:0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
